// File: rtl/match_report_pkg.sv
// Shared types and default sizes for the match report collector.
package match_report_pkg;

  localparam int OFFSET_W_DEF   = 32;
  localparam int COUNT_W_DEF    = 32;
  localparam int FIFO_DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_STREAM,
    ST_DRAIN,
    ST_EOS,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [OFFSET_W_DEF-1:0] offset;
    logic                    eos;
  } report_t;

endpackage

// File: rtl/report_fifo.sv
// Synchronous FIFO for queued match offsets.
module report_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;
  logic          w_wr;
  logic          w_rd;

  // DEPTH is a power of two, so the count MSB is the full flag
  assign full  = r_cnt[AW];
  assign empty = (r_cnt == '0);
  assign rdata = r_mem[r_rptr];
  assign w_rd  = pop && !empty;
  assign w_wr  = push && (!full || w_rd);

  always_ff @(posedge clock) begin
    if (w_wr) r_mem[r_wptr] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      if (w_wr && !w_rd)
        r_cnt <= r_cnt + 1'b1;
      else if (w_rd && !w_wr)
        r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/match_report_collector.sv
// Collects matcher hits into offset reports, then emits an EOS record.
module match_report_collector
  import match_report_pkg::*;
#(
  parameter int OFFSET_W   = OFFSET_W_DEF,
  parameter int COUNT_W    = COUNT_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                in_valid,
  input  logic                in_result,
  input  logic                in_last,
  output logic                in_ready,
  output logic                rpt_valid,
  input  logic                rpt_ready,
  output logic [OFFSET_W-1:0] rpt_offset,
  output logic                rpt_eos,
  output logic [COUNT_W-1:0]  match_count,
  output logic [COUNT_W-1:0]  drop_count,
  output logic                overflow,
  output logic                done
);

  state_t              r_state;
  logic [OFFSET_W-1:0] r_offset;
  logic [COUNT_W-1:0]  r_match;
  logic [COUNT_W-1:0]  r_drop;
  logic                r_ovf;

  logic                w_accept;
  logic                w_restart;
  logic                w_qphase;
  logic                w_push;
  logic                w_pop;
  logic                w_drop;
  logic                w_full;
  logic                w_empty;
  logic [OFFSET_W-1:0] w_base;
  logic [OFFSET_W-1:0] w_head;
  logic [COUNT_W-1:0]  w_mbase;
  logic [COUNT_W-1:0]  w_dbase;

  assign in_ready  = (r_state == ST_STREAM) ||
                     (r_state == ST_DONE);
  assign w_accept  = in_valid && in_ready;
  assign w_restart = w_accept && (r_state == ST_DONE);
  assign w_qphase  = (r_state == ST_STREAM) ||
                     (r_state == ST_DRAIN);

  assign rpt_valid = w_qphase ? !w_empty
                              : (r_state == ST_EOS);
  assign rpt_eos   = (r_state == ST_EOS);
  assign rpt_offset = rpt_eos   ? r_offset :
                      rpt_valid ? w_head   : '0;

  assign w_pop  = w_qphase && rpt_valid && rpt_ready;
  assign w_push = w_accept && in_result;
  assign w_drop = w_push && w_full && !w_pop;

  // The first byte after DONE starts a fresh stream from zero
  assign w_base  = w_restart ? '0 : r_offset;
  assign w_mbase = w_restart ? '0 : r_match;
  assign w_dbase = w_restart ? '0 : r_drop;

  assign match_count = r_match;
  assign drop_count  = r_drop;
  assign overflow    = r_ovf;
  assign done        = (r_state == ST_DONE);

  report_fifo #(
    .W     (OFFSET_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (w_push),
    .pop     (w_pop),
    .wdata   (w_base),
    .rdata   (w_head),
    .full    (w_full),
    .empty   (w_empty)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state  <= ST_STREAM;
      r_offset <= '0;
      r_match  <= '0;
      r_drop   <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_offset <= w_base + 1'b1;
        r_match  <= (w_push && (w_mbase != '1))
                    ? w_mbase + 1'b1 : w_mbase;
        r_drop   <= (w_drop && (w_dbase != '1))
                    ? w_dbase + 1'b1 : w_dbase;
        r_ovf    <= (r_ovf && !w_restart) || w_drop;
      end
      unique case (r_state)
        ST_STREAM, ST_DONE: begin
          if (w_accept)
            r_state <= in_last ? ST_DRAIN : ST_STREAM;
        end
        ST_DRAIN: begin
          if (w_empty) r_state <= ST_EOS;
        end
        ST_EOS: begin
          if (rpt_ready) r_state <= ST_DONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_match_report_collector.sv
// Self-checking bench: queue-based reference model plus directed and random streams.
module tb_match_report_collector;
  import match_report_pkg::*;

  localparam int DEPTH    = 8;
  localparam int P_STREAM = 0;
  localparam int P_DRAIN  = 1;
  localparam int P_EOS    = 2;
  localparam int P_DONE   = 3;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_result = 1'b0;
  logic in_last = 1'b0;
  logic rpt_ready = 1'b0;
  logic in_ready;
  logic rpt_valid;
  logic rpt_eos;
  logic overflow;
  logic done;
  logic [31:0] rpt_offset;
  logic [31:0] match_count;
  logic [31:0] drop_count;

  int n_chk = 0;
  int n_fail = 0;

  match_report_collector #(
    .OFFSET_W   (32),
    .COUNT_W    (32),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_result   (in_result),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .rpt_valid   (rpt_valid),
    .rpt_ready   (rpt_ready),
    .rpt_offset  (rpt_offset),
    .rpt_eos     (rpt_eos),
    .match_count (match_count),
    .drop_count  (drop_count),
    .overflow    (overflow),
    .done        (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // Reference model: stream phase, queue of pending offsets, counters
  int          m_phase = P_STREAM;
  logic [31:0] mq[$];
  logic [31:0] m_off = 0;
  logic [31:0] m_mc = 0;
  logic [31:0] m_dc = 0;
  logic        m_ovf = 1'b0;

  always @(posedge clock) begin : model
    int sz;
    int nph;
    bit qph;
    bit rdy;
    bit vld;
    bit pop;
    bit acc;
    if (!reset_n) begin
      m_phase = P_STREAM;
      mq.delete();
      m_off = 0;
      m_mc = 0;
      m_dc = 0;
      m_ovf = 1'b0;
    end else begin
      sz  = mq.size();
      qph = (m_phase == P_STREAM) || (m_phase == P_DRAIN);
      rdy = (m_phase == P_STREAM) || (m_phase == P_DONE);
      vld = qph ? (sz > 0) : (m_phase == P_EOS);
      pop = vld && rpt_ready;
      acc = in_valid && rdy;
      nph = m_phase;
      if (m_phase == P_DRAIN && sz == 0) nph = P_EOS;
      if (m_phase == P_EOS && pop) nph = P_DONE;
      if (pop && qph) void'(mq.pop_front());
      if (acc) begin
        if (m_phase == P_DONE) begin
          m_off = 0;
          m_mc = 0;
          m_dc = 0;
          m_ovf = 1'b0;
        end
        if (in_result) begin
          if (m_mc != 32'hFFFF_FFFF) m_mc++;
          if (sz < DEPTH || (pop && qph)) mq.push_back(m_off);
          else begin
            if (m_dc != 32'hFFFF_FFFF) m_dc++;
            m_ovf = 1'b1;
          end
        end
        m_off++;
        nph = in_last ? P_DRAIN : P_STREAM;
      end
      m_phase = nph;
    end
  end

  report_t got[$];
  report_t exp_q[$];
  bit      hold = 1'b0;
  report_t held;

  always @(negedge clock) begin : compare
    bit e_rdy;
    bit e_vld;
    bit e_eos;
    logic [31:0] e_off;
    e_rdy = (m_phase == P_STREAM) || (m_phase == P_DONE);
    e_eos = (m_phase == P_EOS);
    e_vld = e_eos || ((m_phase == P_STREAM || m_phase == P_DRAIN)
                      && mq.size() > 0);
    e_off = e_eos ? m_off : (mq.size() > 0 ? mq[0] : 32'd0);
    chk("in_ready", in_ready, e_rdy);
    chk("rpt_valid", rpt_valid, e_vld);
    if (e_vld) begin
      chk("rpt_offset", rpt_offset, e_off);
      chk("rpt_eos", rpt_eos, e_eos);
    end
    chk("match_count", match_count, m_mc);
    chk("drop_count", drop_count, m_dc);
    chk("overflow", overflow, m_ovf);
    chk("done", done, m_phase == P_DONE);
    if (hold)
      chk("rpt_hold", {rpt_valid, rpt_eos, rpt_offset},
          {1'b1, held.eos, held.offset});
    hold = rpt_valid && !rpt_ready && reset_n;
    held.offset = rpt_offset;
    held.eos = rpt_eos;
    if (rpt_valid && rpt_ready) got.push_back(held);
  end

  function automatic report_t rec(input logic [31:0] o, input logic e);
    report_t r;
    r.offset = o;
    r.eos = e;
    return r;
  endfunction

  task automatic chk_got(input string nm);
    chk({nm, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_rec%0d", nm, i), got[i], exp_q[i]);
  endtask

  task automatic cyc(input logic v, input logic r, input logic l);
    in_valid = v;
    in_result = r;
    in_last = l;
    @(posedge clock);
    #1;
  endtask

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    in_valid = 1'b0;
    in_result = 1'b0;
    in_last = 1'b0;
    while (!done && k < 300) begin
      @(posedge clock);
      #1;
      k++;
    end
    chk({nm, "_done"}, done, 1'b1);
  endtask

  initial begin
    int rbias;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_rpt_valid", rpt_valid, 1'b0);
    chk("rst_rpt_offset", rpt_offset, 0);
    chk("rst_rpt_eos", rpt_eos, 1'b0);
    chk("rst_match_count", match_count, 0);
    chk("rst_drop_count", drop_count, 0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_done", done, 1'b0);
    reset_n = 1'b1;

    // 6 bytes, hits at 1 and 4
    rpt_ready = 1'b1;
    got.delete();
    for (int i = 0; i < 6; i++) cyc(1'b1, i == 1 || i == 4, i == 5);
    wait_done("s1");
    exp_q.delete();
    exp_q.push_back(rec(1, 0));
    exp_q.push_back(rec(4, 0));
    exp_q.push_back(rec(6, 1));
    chk_got("s1");
    chk("s1_match_count", match_count, 2);
    chk("s1_overflow", overflow, 1'b0);

    // 5 bytes, no hits
    got.delete();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, i == 4);
    wait_done("s2");
    exp_q.delete();
    exp_q.push_back(rec(5, 1));
    chk_got("s2");
    chk("s2_match_count", match_count, 0);

    // 12 hits into a stalled 8-entry queue
    rpt_ready = 1'b0;
    got.delete();
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1, i == 11);
    cyc(1'b0, 1'b0, 1'b0);
    chk("s3_match_count", match_count, 12);
    chk("s3_drop_count", drop_count, 4);
    chk("s3_overflow", overflow, 1'b1);
    rpt_ready = 1'b1;
    wait_done("s3");
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(rec(i, 0));
    exp_q.push_back(rec(12, 1));
    chk_got("s3");

    // push into a full queue while it pops
    rpt_ready = 1'b0;
    got.delete();
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0);
    rpt_ready = 1'b1;
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    wait_done("s4");
    exp_q.delete();
    for (int i = 0; i < 10; i++) exp_q.push_back(rec(i, 0));
    exp_q.push_back(rec(10, 1));
    chk_got("s4");
    chk("s4_drop_count", drop_count, 0);
    chk("s4_overflow", overflow, 1'b0);

    // bytes offered during DRAIN are ignored
    rpt_ready = 1'b0;
    got.delete();
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("s5_in_ready", in_ready, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
    end
    rpt_ready = 1'b1;
    wait_done("s5");
    exp_q.delete();
    exp_q.push_back(rec(0, 0));
    exp_q.push_back(rec(3, 1));
    chk_got("s5");
    chk("s5_match_count", match_count, 1);

    // reset in the middle of DRAIN
    rpt_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, i == 2);
    reset_n = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    chk("s6_rpt_valid", rpt_valid, 1'b0);
    chk("s6_match_count", match_count, 0);
    chk("s6_in_ready", in_ready, 1'b1);
    rpt_ready = 1'b1;
    got.delete();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    wait_done("s6a");
    exp_q.delete();
    exp_q.push_back(rec(1, 0));
    exp_q.push_back(rec(2, 1));
    chk_got("s6a");
    got.delete();
    cyc(1'b1, 1'b1, 1'b1);
    chk("s6_restart_mc", match_count, 1);
    chk("s6_restart_dc", drop_count, 0);
    wait_done("s6b");
    exp_q.delete();
    exp_q.push_back(rec(0, 0));
    exp_q.push_back(rec(1, 1));
    chk_got("s6b");

    // random traffic against the model
    got.delete();
    rbias = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) rbias = int'($urandom_range(0, 3));
      rpt_ready = ($urandom_range(0, 3) <= rbias);
      reset_n = ($urandom_range(0, 599) != 0);
      cyc($urandom_range(0, 3) != 0,
          $urandom_range(0, 2) == 0,
          $urandom_range(0, 11) == 0);
    end
    reset_n = 1'b1;
    repeat (2) cyc(1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/match_report_collector.md
Name: match_report_collector

Overview:
- Downstream consumer of the STE automaton matcher.
- Each cycle it takes the matcher's per-byte `result` bit and its own valid qualifier, and keeps a running byte offset.
- For every byte where a match fires, it queues that byte's offset. The queued offsets go out as report records over a valid/ready interface.
- When the input stream ends, it drains the queue and then emits one end-of-stream (EOS) record carrying the total byte count.

Parameters:
- OFFSET_W, 32, width of byte-offset counter and report offset field
- COUNT_W, 32, width of match and drop counters
- FIFO_DEPTH, 8, report queue entries (power of two, >= 2)

Ports:
- clock  in  1  single clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- in_valid  in  1  byte consumed by matcher this cycle; in_result meaningful
- in_result  in  1  matcher `result` for this byte
- in_last  in  1  this byte is the final byte of the stream (qualified by in_valid)
- in_ready  out  1  collector accepting bytes (0 during DRAIN/EOS)
- rpt_valid  out  1  report record available
- rpt_ready  in  1  consumer accepts record
- rpt_offset  out  OFFSET_W  match: 0-based byte offset of the match-end byte; EOS: total bytes in stream
- rpt_eos  out  1  record is the end-of-stream marker
- match_count  out  COUNT_W  matches seen in current stream, including dropped
- drop_count  out  COUNT_W  matches lost to a full queue
- overflow  out  1  sticky: at least one drop this stream
- done  out  1  EOS record handshaken; collector idle

Behaviour:
- Accept condition: a byte is accepted when in_valid && in_ready. Bytes with in_valid=1 while in_ready=0 are ignored (no offset advance, no push).
- Reset values: all outputs 0 except in_ready=1. State=STREAM. Queue empty. Offset counter 0.
- Reset is honoured in any state, including mid-drain: the queue is flushed and counters are cleared.

State machine:
- STREAM:
  - Each accepted byte increments the offset counter, which wraps modulo 2^OFFSET_W.
  - If in_result=1, the pre-increment offset is pushed and match_count is incremented.
  - An accepted byte with in_last=1 moves the state to DRAIN, after processing its own result.
- DRAIN:
  - in_ready=0.
  - The queue pops on rpt_valid && rpt_ready.
  - When the queue is empty, the state moves to EOS.
- EOS:
  - rpt_valid=1, rpt_eos=1, rpt_offset = total bytes (the offset counter).
  - On handshake, move to DONE.
- DONE:
  - done=1, in_ready=1, rpt_valid=0.
  - The next accepted byte clears the offset, match_count, drop_count and overflow, then is processed as the first byte of a new stream (offset 0). State goes to STREAM (or straight to DRAIN if that byte has in_last=1).

Queue and handshake rules:
- Push when full with no pop in the same cycle: the record is dropped, drop_count is incremented, overflow is set.
- Push when full with a pop in the same cycle: the push succeeds.
- Latency: a match accepted in cycle N is visible on rpt_* at cycle N+1 at the earliest.
- Records leave in push order.
- rpt_* are held stable while rpt_valid && !rpt_ready.
- rpt_eos=0 on all match records.
- Counters saturate at 2^COUNT_W-1; the offset counter wraps.
- Simultaneous push and pop with the queue empty: the pushed record appears the next cycle (no fall-through).

Decomposition:
- Shared package `match_report_pkg`:
  - state enum {STREAM, DRAIN, EOS, DONE};
  - report record struct {offset, eos};
  - default width constants.
- One sub-module `report_fifo`: parameterised synchronous FIFO.
  - Signals: push/pop, full/empty, registered read data.
  - Simultaneous push/pop is legal when full.
- The top level holds the FSM, counters and the drop logic.

Test Plan:
- Stream of 6 bytes, in_result on bytes 1 and 4, in_last on byte 5, rpt_ready=1 → records offset 1, offset 4, then EOS offset 6. done=1, match_count=2, overflow=0.
- Stream of 5 bytes with no matches, in_last on byte 4 → single EOS record, offset 5. match_count=0.
- rpt_ready=0, FIFO_DEPTH=8, 12 consecutive matching bytes (offsets 0..11) → queue holds 0..7. drop_count=4, match_count=12, overflow=1. After rpt_ready=1: records 0..7, then EOS offset 12.
- Queue full with rpt_ready=1 and a match in the same cycle → no drop. Ordering is preserved; drop_count stays 0.
- in_valid=1 asserted during DRAIN → in_ready=0 and the byte is ignored. EOS offset equals the bytes accepted before in_last.
- reset_n=0 for one cycle mid-DRAIN with 3 queued records → next cycle rpt_valid=0, counters 0, state STREAM. A new stream starts at offset 0. After DONE, a new stream also restarts at offset 0 with counters cleared.
